// File: rtl/riscv_defs_pkg.sv
// riscv_defs: shared funct3 codes, MEM-stage FSM states and the misalignment rule.
// Imported by mem_access_stage and mem_lane_align; no ports.
package riscv_defs;
   localparam logic [2:0] INST_LB  = 3'b000;
   localparam logic [2:0] INST_LH  = 3'b001;
   localparam logic [2:0] INST_LW  = 3'b010;
   localparam logic [2:0] INST_LBU = 3'b100;
   localparam logic [2:0] INST_LHU = 3'b101;
   localparam logic [2:0] INST_SB  = 3'b000;
   localparam logic [2:0] INST_SH  = 3'b001;
   localparam logic [2:0] INST_SW  = 3'b010;

   typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

   // Store codes share their low bits with the load codes, so one rule covers both.
   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
      return ((f3 == INST_LH || f3 == INST_LHU) && a[0]) || (f3 == INST_LW && a != 2'b00);
   endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane steering for stores and loads.
// Ports: store_i/funct3_i/a_i select the access; rs2_i -> be_o/wdata_o (store side);
//        rdata_i -> ld_data_o (load side, right-justified, upper bits zero).
module mem_lane_align
   import riscv_defs::*;
(
   input  logic        store_i,
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  a_i,
   input  logic [31:0] rs2_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] ld_data_o
);
   logic [31:0] byte_sh;
   logic        is_b;
   logic        is_h;

   assign byte_sh   = rdata_i >> {a_i, 3'b000};
   assign is_b      = funct3_i == INST_LB || funct3_i == INST_LBU;
   assign is_h      = funct3_i == INST_LH || funct3_i == INST_LHU;
   assign be_o      = !store_i                ? 4'b1111 :
                      funct3_i == INST_SB     ? 4'b0001 << a_i :
                      funct3_i == INST_SH     ? (a_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
   assign wdata_o   = !store_i                ? rs2_i :
                      funct3_i == INST_SB     ? {4{rs2_i[7:0]}} :
                      funct3_i == INST_SH     ? {2{rs2_i[15:0]}} : rs2_i;
   assign ld_data_o = is_b ? {24'b0, byte_sh[7:0]} :
                      is_h ? {16'b0, a_i[1] ? rdata_i[31:16] : rdata_i[15:0]} : rdata_i;
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage issuing data-memory accesses and registering the WB bundle.
// Ports: ex_* from EX/MEM; mem_stall freezes upstream; dmem_* ready-handshake memory port;
//        wb_* registered write-back bundle; mem_err pulses on a wait-state timeout.
// Optional: MEM_MISALIGN_TRAP_EN adds mem_misalign / mem_bad_addr and traps misaligned accesses.
module mem_access_stage
   import riscv_defs::*;
#(
   parameter int MAX_WAIT = 15,
   parameter int CNT_W    = 8
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        ex_valid,
   input  logic        ex_mem_read,
   input  logic        ex_mem_write,
   input  logic        ex_reg_write,
   input  logic [2:0]  ex_funct3,
   input  logic [4:0]  ex_rd_addr,
   input  logic [31:0] ex_alu_result,
   input  logic [31:0] ex_rs2_data,
   input  logic [31:0] ex_pc,
   output logic        mem_stall,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ready,
   output logic        wb_reg_write,
   output logic        wb_mem_to_reg,
   output logic [2:0]  wb_funct3,
   output logic [4:0]  wb_rd_addr,
   output logic [31:0] wb_mem_data,
   output logic [31:0] wb_pc,
   output logic        mem_err
`ifdef MEM_MISALIGN_TRAP_EN
   ,
   output logic        mem_misalign,
   output logic [31:0] mem_bad_addr
`endif
);
   // The abort fires on the edge where the counter would reach MAX_WAIT.
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_WAIT - 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              req_q, req_d, we_q, we_d, rw_q, rw_d;
   logic [31:0]       addr_q, addr_d, wdata_q, wdata_d, pc_q, pc_d;
   logic [3:0]        be_q, be_d;
   logic [2:0]        f3_q, f3_d;
   logic [4:0]        rd_q, rd_d;
   logic              wb_rw_q, wb_rw_d, wb_m2r_q, wb_m2r_d, err_q, err_d;
   logic [2:0]        wb_f3_q, wb_f3_d;
   logic [4:0]        wb_rd_q, wb_rd_d;
   logic [31:0]       wb_data_q, wb_data_d, wb_pc_q, wb_pc_d;
   logic              idle, is_mem, trap, issue;
   logic [3:0]        al_be;
   logic [31:0]       al_wdata, al_ld;

   assign idle      = state_q == ST_IDLE;
   assign is_mem    = ex_valid && (ex_mem_read || ex_mem_write);
   assign issue     = idle && is_mem && !trap;
   assign mem_stall = !idle || issue;

`ifdef MEM_MISALIGN_TRAP_EN
   logic        mis_q, mis_d;
   logic [31:0] bad_q, bad_d;
   assign trap         = is_mem && misaligned(ex_funct3, ex_alu_result[1:0]);
   assign mis_d        = idle && trap;
   assign bad_d        = (idle && trap) ? ex_alu_result : bad_q;
   assign mem_misalign = mis_q;
   assign mem_bad_addr = bad_q;
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mis_q <= 1'b0;
         bad_q <= '0;
      end else begin
         mis_q <= mis_d;
         bad_q <= bad_d;
      end
   end
`else
   assign trap = 1'b0;
`endif

   // Issue side steers from the live EX inputs; completion side uses the captured access.
   mem_lane_align u_align (
      .store_i   (idle ? ex_mem_write : we_q),
      .funct3_i  (idle ? ex_funct3 : f3_q),
      .a_i       (idle ? ex_alu_result[1:0] : addr_q[1:0]),
      .rs2_i     (ex_rs2_data),
      .rdata_i   (dmem_rdata),
      .be_o      (al_be),
      .wdata_o   (al_wdata),
      .ld_data_o (al_ld)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      req_d     = req_q;
      we_d      = we_q;
      rw_d      = rw_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      pc_d      = pc_q;
      be_d      = be_q;
      f3_d      = f3_q;
      rd_d      = rd_q;
      wb_rw_d   = 1'b0;
      wb_m2r_d  = 1'b0;
      wb_f3_d   = wb_f3_q;
      wb_rd_d   = wb_rd_q;
      wb_data_d = wb_data_q;
      wb_pc_d   = wb_pc_q;
      err_d     = 1'b0;
      if (idle) begin
         if (!is_mem) begin
            wb_rw_d   = ex_valid && ex_reg_write;
            wb_f3_d   = ex_funct3;
            wb_rd_d   = ex_rd_addr;
            wb_data_d = ex_alu_result;
            wb_pc_d   = ex_pc;
         end
         if (issue) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
            req_d   = 1'b1;
            we_d    = ex_mem_write;
            rw_d    = ex_reg_write;
            addr_d  = ex_alu_result;
            wdata_d = al_wdata;
            be_d    = al_be;
            pc_d    = ex_pc;
            f3_d    = ex_funct3;
            rd_d    = ex_rd_addr;
         end
      end else if (dmem_ready) begin
         state_d   = ST_IDLE;
         cnt_d     = '0;
         req_d     = 1'b0;
         wb_rw_d   = rw_q && !we_q;
         wb_m2r_d  = !we_q;
         wb_f3_d   = f3_q;
         wb_rd_d   = rd_q;
         wb_data_d = al_ld;
         wb_pc_d   = pc_q;
      end else if (cnt_q == LAST_CNT) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         req_d   = 1'b0;
         err_d   = 1'b1;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         rw_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         pc_q      <= '0;
         be_q      <= '0;
         f3_q      <= '0;
         rd_q      <= '0;
         wb_rw_q   <= 1'b0;
         wb_m2r_q  <= 1'b0;
         wb_f3_q   <= '0;
         wb_rd_q   <= '0;
         wb_data_q <= '0;
         wb_pc_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         req_q     <= req_d;
         we_q      <= we_d;
         rw_q      <= rw_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         pc_q      <= pc_d;
         be_q      <= be_d;
         f3_q      <= f3_d;
         rd_q      <= rd_d;
         wb_rw_q   <= wb_rw_d;
         wb_m2r_q  <= wb_m2r_d;
         wb_f3_q   <= wb_f3_d;
         wb_rd_q   <= wb_rd_d;
         wb_data_q <= wb_data_d;
         wb_pc_q   <= wb_pc_d;
         err_q     <= err_d;
      end
   end

   assign dmem_req      = req_q;
   assign dmem_we       = we_q;
   assign dmem_addr     = {addr_q[31:2], 2'b00};
   assign dmem_be       = be_q;
   assign dmem_wdata    = wdata_q;
   assign wb_reg_write  = wb_rw_q;
   assign wb_mem_to_reg = wb_m2r_q;
   assign wb_funct3     = wb_f3_q;
   assign wb_rd_addr    = wb_rd_q;
   assign wb_mem_data   = wb_data_q;
   assign wb_pc         = wb_pc_q;
   assign mem_err       = err_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: table-driven and randomized self-checking bench for mem_access_stage.
module tb_mem_access_stage;
   localparam int MW = 4;

   logic        clk = 1'b0, rstn;
   logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write;
   logic [2:0]  ex_funct3;
   logic [4:0]  ex_rd_addr;
   logic [31:0] ex_alu_result, ex_rs2_data, ex_pc;
   logic        mem_stall, dmem_req, dmem_we, dmem_ready;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic        wb_reg_write, wb_mem_to_reg, mem_err;
   logic [2:0]  wb_funct3;
   logic [4:0]  wb_rd_addr;
   logic [31:0] wb_mem_data, wb_pc;
`ifdef MEM_MISALIGN_TRAP_EN
   logic        mem_misalign;
   logic [31:0] mem_bad_addr;
`endif

   always #5 clk = ~clk;

   mem_access_stage #(.MAX_WAIT(MW), .CNT_W(8)) dut (
      .clk(clk), .rstn(rstn),
      .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_reg_write(ex_reg_write), .ex_funct3(ex_funct3), .ex_rd_addr(ex_rd_addr),
      .ex_alu_result(ex_alu_result), .ex_rs2_data(ex_rs2_data), .ex_pc(ex_pc),
      .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
      .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_funct3(wb_funct3),
      .wb_rd_addr(wb_rd_addr), .wb_mem_data(wb_mem_data), .wb_pc(wb_pc), .mem_err(mem_err)
`ifdef MEM_MISALIGN_TRAP_EN
      , .mem_misalign(mem_misalign), .mem_bad_addr(mem_bad_addr)
`endif
   );

   int total = 0, bad = 0;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", n, act, exp);
      end
   endtask

   // lat: ready on the lat-th WAIT cycle; 0 or >MW means memory never answers.
   typedef struct {
      logic        valid, rd, wr, rw;
      logic [2:0]  f3;
      logic [4:0]  rda;
      logic [31:0] addr, rs2, rdata, pc;
      int          lat;
      logic [3:0]  e_be;
      logic [31:0] e_wdata, e_data;
      logic        e_rw, e_m2r, e_err, e_trap;
   } vec_t;

   function automatic vec_t row(logic valid, logic rd, logic wr, logic rw, logic [2:0] f3,
                                logic [4:0] rda, logic [31:0] addr, logic [31:0] rs2,
                                logic [31:0] rdata, int lat, logic [3:0] e_be,
                                logic [31:0] e_wdata, logic [31:0] e_data, logic e_rw,
                                logic e_m2r, logic e_err, logic e_trap);
      vec_t v;
      v.valid = valid; v.rd = rd; v.wr = wr; v.rw = rw; v.f3 = f3; v.rda = rda;
      v.addr = addr; v.rs2 = rs2; v.rdata = rdata; v.pc = addr + 32'h100; v.lat = lat;
      v.e_be = e_be; v.e_wdata = e_wdata; v.e_data = e_data;
      v.e_rw = e_rw; v.e_m2r = e_m2r; v.e_err = e_err; v.e_trap = e_trap;
      return v;
   endfunction

   // Reference: expected results derived from the access rules with plain arithmetic.
   function automatic vec_t model(vec_t v);
      int  a = int'(v.addr[1:0]);
      bit  mem = v.valid && (v.rd || v.wr);
      bit  fin;
      v.e_trap = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      if (mem) v.e_trap = ((v.f3 == 3'd1 || v.f3 == 3'd5) && (a % 2 == 1)) || (v.f3 == 3'd2 && a != 0);
`endif
      v.e_err = mem && !v.e_trap && (v.lat < 1 || v.lat > MW);
      fin = mem && !v.e_trap && !v.e_err;
      v.e_be = 4'hF;
      v.e_wdata = v.rs2;
      if (v.wr && v.f3 == 3'd0) begin
         v.e_be = 4'(1 << a);
         v.e_wdata = (v.rs2 & 32'hFF) * 32'h01010101;
      end
      if (v.wr && v.f3 == 3'd1) begin
         v.e_be = 4'(3 << (2 * (a / 2)));
         v.e_wdata = (v.rs2 & 32'hFFFF) * 32'h00010001;
      end
      v.e_data = v.addr;
      if (fin && !v.wr)
         v.e_data = (v.f3 == 3'd0 || v.f3 == 3'd4) ? (v.rdata >> (8 * a)) & 32'hFF :
                    (v.f3 == 3'd1 || v.f3 == 3'd5) ? (v.rdata >> (16 * (a / 2))) & 32'hFFFF : v.rdata;
      v.e_rw  = mem ? (fin && !v.wr && v.rw) : (v.valid && v.rw);
      v.e_m2r = fin && !v.wr;
      return v;
   endfunction

   task automatic run_op(input vec_t v);
      bit mem = v.valid && (v.rd || v.wr);
      bit fin = 0;
      ex_valid = v.valid; ex_mem_read = v.rd; ex_mem_write = v.wr; ex_reg_write = v.rw;
      ex_funct3 = v.f3; ex_rd_addr = v.rda; ex_alu_result = v.addr; ex_rs2_data = v.rs2;
      ex_pc = v.pc; dmem_ready = 1'b0;
      #1 chk("stall_issue", mem_stall, mem && !v.e_trap);
      @(posedge clk); #1;
      chk("err_quiet", mem_err, 0);
      if (!mem || v.e_trap) begin
         chk("req_idle", dmem_req, 0);
         chk("wb_rw", wb_reg_write, v.e_rw);
         chk("wb_m2r", wb_mem_to_reg, 0);
         if (v.valid && !mem) begin
            chk("wb_data_alu", wb_mem_data, v.e_data);
            chk("wb_rd_alu", wb_rd_addr, v.rda);
            chk("wb_pc_alu", wb_pc, v.pc);
         end
`ifdef MEM_MISALIGN_TRAP_EN
         chk("misalign", mem_misalign, v.e_trap);
         if (v.e_trap) chk("bad_addr", mem_bad_addr, v.addr);
`endif
      end else begin
         chk("req_on", dmem_req, 1);
         chk("we", dmem_we, v.wr);
         chk("addr", dmem_addr, {v.addr[31:2], 2'b00});
         chk("be", dmem_be, v.e_be);
         if (v.wr) chk("wdata", dmem_wdata, v.e_wdata);
         chk("wb_bubble", wb_reg_write, 0);
         for (int i = 1; i <= MW && !fin; i++) begin
            ex_valid = 1'($urandom); ex_mem_read = 1'($urandom); ex_mem_write = 1'($urandom);
            ex_funct3 = 3'($urandom); ex_rd_addr = 5'($urandom); ex_alu_result = $urandom;
            ex_rs2_data = $urandom; ex_pc = $urandom;
            dmem_ready = (i == v.lat);
            dmem_rdata = (i == v.lat) ? v.rdata : $urandom;
            #1 chk("stall_wait", mem_stall, 1);
            chk("req_hold", dmem_req, 1);
            chk("addr_hold", dmem_addr, {v.addr[31:2], 2'b00});
            @(posedge clk); #1;
            dmem_ready = 1'b0;
            if (i == v.lat) begin
               fin = 1;
               chk("req_drop", dmem_req, 0);
               chk("err_none", mem_err, 0);
               chk("wb_rw_mem", wb_reg_write, v.e_rw);
               chk("wb_m2r_mem", wb_mem_to_reg, v.e_m2r);
               if (!v.wr) begin
                  chk("wb_ld_data", wb_mem_data, v.e_data);
                  chk("wb_funct3", wb_funct3, v.f3);
                  chk("wb_rd_ld", wb_rd_addr, v.rda);
                  chk("wb_pc_ld", wb_pc, v.pc);
               end
            end else if (i == MW) begin
               fin = 1;
               chk("req_abort", dmem_req, 0);
               chk("err_pulse", mem_err, v.e_err);
               chk("wb_rw_abort", wb_reg_write, 0);
            end
         end
      end
      ex_valid = 1'b0;
   endtask

   vec_t tbl[$];
   vec_t v;
   int   ld_f3[5] = '{0, 1, 2, 4, 5};

   initial begin
      rstn = 1'b0;
      ex_valid = 0; ex_mem_read = 0; ex_mem_write = 0; ex_reg_write = 0; ex_funct3 = 0;
      ex_rd_addr = 0; ex_alu_result = 0; ex_rs2_data = 0; ex_pc = 0;
      dmem_rdata = 0; dmem_ready = 0;
      #12;
      chk("rst_req", dmem_req, 0);
      chk("rst_we", dmem_we, 0);
      chk("rst_addr", dmem_addr, 0);
      chk("rst_be", dmem_be, 0);
      chk("rst_wdata", dmem_wdata, 0);
      chk("rst_wb_rw", wb_reg_write, 0);
      chk("rst_wb_data", wb_mem_data, 0);
      chk("rst_wb_pc", wb_pc, 0);
      chk("rst_err", mem_err, 0);
      chk("rst_stall", mem_stall, 0);
      @(posedge clk); #1 rstn = 1'b1;

      // inputs: valid rd wr rw f3 rd addr rs2 rdata lat | be wdata data rw m2r err trap
      tbl.push_back(row(1, 0, 0, 1, 3'd0, 5'd5, 32'h1234, 0, 0, 1, 4'hF, 0, 32'h1234, 1, 0, 0, 0));
      tbl.push_back(row(1, 0, 1, 0, 3'd0, 5'd0, 32'h1003, 32'hAABBCCDD, 0, 1,
                        4'b1000, 32'hDDDDDDDD, 0, 0, 0, 0, 0));
      tbl.push_back(row(1, 1, 0, 1, 3'd1, 5'd7, 32'h2002, 0, 32'h87654321, 4,
                        4'hF, 0, 32'h00008765, 1, 1, 0, 0));
      tbl.push_back(row(1, 1, 0, 1, 3'd2, 5'd9, 32'h4000, 0, 0, 0, 4'hF, 0, 0, 0, 0, 1, 0));
      tbl.push_back(row(1, 0, 1, 0, 3'd1, 5'd0, 32'h1006, 32'h1234ABCD, 0, 2,
                        4'b1100, 32'hABCDABCD, 0, 0, 0, 0, 0));
      tbl.push_back(row(1, 1, 0, 1, 3'd4, 5'd3, 32'h1001, 0, 32'h11223344, 3,
                        4'hF, 0, 32'h00000033, 1, 1, 0, 0));
      tbl.push_back(row(0, 0, 0, 1, 3'd0, 5'd4, 32'h5555, 0, 0, 1, 4'hF, 0, 0, 0, 0, 0, 0));
`ifdef MEM_MISALIGN_TRAP_EN
      tbl.push_back(row(1, 1, 0, 1, 3'd2, 5'd6, 32'h3001, 0, 32'hCAFEF00D, 1,
                        4'hF, 0, 0, 0, 0, 0, 1));
`else
      tbl.push_back(row(1, 1, 0, 1, 3'd2, 5'd6, 32'h3001, 0, 32'hCAFEF00D, 1,
                        4'hF, 0, 32'hCAFEF00D, 1, 1, 0, 0));
`endif
      foreach (tbl[i]) run_op(tbl[i]);

`ifdef MEM_MISALIGN_TRAP_EN
      @(posedge clk); #1;
      chk("misalign_drop", mem_misalign, 0);
      chk("bad_addr_hold", mem_bad_addr, 32'h3001);
`endif

      // Reset in the middle of a WAIT abandons the access.
      run_op(tbl[0]);
      ex_valid = 1; ex_mem_read = 1; ex_mem_write = 0; ex_reg_write = 1; ex_funct3 = 3'd2;
      ex_rd_addr = 5'd11; ex_alu_result = 32'h5000; ex_pc = 32'h80;
      @(posedge clk); #1;
      chk("rstw_req_on", dmem_req, 1);
      @(posedge clk); #2;
      rstn = 1'b0;
      #1;
      chk("rstw_req", dmem_req, 0);
      chk("rstw_wb_data", wb_mem_data, 0);
      chk("rstw_wb_pc", wb_pc, 0);
      chk("rstw_wb_rd", wb_rd_addr, 0);
      chk("rstw_err", mem_err, 0);
      ex_valid = 1'b0;
      @(posedge clk); #1 rstn = 1'b1;
      run_op(tbl[0]);

      for (int n = 0; n < 150; n++) begin
         int k = int'($urandom_range(0, 3));
         v.valid = k != 3; v.rd = k == 1; v.wr = k == 2; v.rw = 1'($urandom);
         v.f3 = k == 1 ? 3'(ld_f3[$urandom_range(0, 4)]) :
                k == 2 ? 3'($urandom_range(0, 2)) : 3'($urandom);
         v.rda = 5'($urandom); v.addr = $urandom; v.rs2 = $urandom;
         v.rdata = $urandom; v.pc = $urandom; v.lat = int'($urandom_range(0, MW + 1));
         run_op(model(v));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
MEM stage of the pipelined CPU, between the EX/MEM register and the WB/ID write-back path feeding the register-file write port.
- Issues load/store requests to data memory over a ready-based handshake with wait states.
- Lane-aligns store data and load data.
- Registers the WB bundle (rd, regWrite, MemtoReg, funct3, data, pc) consumed by the decode stage.
- Load sign/zero extension is done downstream. This block delivers the selected byte/halfword right-justified with upper bits zero.

Parameters:
MAX_WAIT, 15, WAIT-state cycles allowed before a memory access is aborted (range 1..255).
CNT_W, 8, width of the wait counter.

Ports:
clk  in  1  pipeline clock
rstn  in  1  asynchronous active-low reset
ex_valid  in  1  EX/MEM slot holds a valid instruction
ex_mem_read  in  1  load instruction
ex_mem_write  in  1  store instruction
ex_reg_write  in  1  instruction writes rd
ex_funct3  in  3  load/store width code
ex_rd_addr  in  5  destination register
ex_alu_result  in  32  effective address, or ALU result for non-memory instructions
ex_rs2_data  in  32  store data
ex_pc  in  32  instruction pc
mem_stall  out  1  freeze IF/ID/EX; combinational
dmem_req  out  1  memory request, registered
dmem_we  out  1  write enable
dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-replicated store data
dmem_rdata  in  32  read word
dmem_ready  in  1  access complete this cycle
wb_reg_write  out  1  WB writes rd
wb_mem_to_reg  out  1  WB data came from memory
wb_funct3  out  3  WB width code
wb_rd_addr  out  5  WB destination
wb_mem_data  out  32  aligned load data or ALU result
wb_pc  out  32  WB pc
mem_err  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset: async, active-low. All outputs 0. State IDLE. Wait counter 0. A reset during WAIT drops dmem_req immediately and the access is abandoned.
- FSM states: IDLE, WAIT.
- IDLE, no memory access (ex_valid and neither read nor write):
  - Next edge loads WB regs: wb_mem_data = ex_alu_result, wb_mem_to_reg = 0, wb_reg_write = ex_reg_write.
  - Latency 1 cycle.
- IDLE, ex_valid and a memory access:
  - mem_stall = 1 this cycle.
  - Next edge captures addr, data, funct3, rd, pc; drives dmem_req = 1 with we, addr, be, wdata; loads a WB bubble (wb_reg_write = 0); goes to WAIT.
- WAIT:
  - mem_stall = 1 and request outputs are held stable.
  - If dmem_ready: next edge deasserts dmem_req, loads WB regs, returns to IDLE, and mem_stall drops. Minimum memory-op latency is 2 cycles.
  - WB regs for a load: wb_mem_to_reg = 1, wb_mem_data = aligned rdata, wb_reg_write = captured ex_reg_write.
  - WB regs for a store: wb_reg_write = 0, wb_mem_to_reg = 0.
- Wait counter: increments each WAIT cycle without ready.
  - Counter reaching MAX_WAIT without ready: abort. dmem_req drops, WB bubble, mem_err pulses 1 cycle, back to IDLE.
  - Ready in the same cycle the counter reaches MAX_WAIT: ready wins, no mem_err.
- ex_* inputs are ignored while in WAIT; upstream holds them because of mem_stall.
- Byte enables and store data, with a = addr[1:0]:
  - SB: be = 1<<a, wdata = {4{rs2[7:0]}}.
  - SH: be = 4'b0011<<(2*a[1]), wdata = {2{rs2[15:0]}}.
  - SW: be = 4'b1111, wdata = rs2.
  - Loads: be = 4'b1111.
- Load alignment:
  - LB/LBU: {24'b0, rdata >> 8*a}.
  - LH/LHU: {16'b0, rdata >> 16*a[1]}.
  - LW: rdata.
  - Other funct3 values: rdata.
- Misalignment (feature off): LH/SH ignore a[0]; LW/SW ignore a[1:0].

Optional Feature:
MEM_MISALIGN_TRAP_EN.
- Defined: adds outputs mem_misalign (1) and mem_bad_addr (32).
  - Misaligned condition: LH/LHU/SH with a[0]=1, or LW/SW with a!=0.
  - On a misaligned access in IDLE: no dmem_req is issued, no stall, WB bubble at the next edge, mem_misalign pulses 1 cycle, and mem_bad_addr is registered with the full address (held until the next trap).
- Undefined: the ports are absent and the low address bits are ignored as above.

Decomposition:
- Shared package/header (riscv_defs):
  - funct3 codes INST_LB/LH/LW/LBU/LHU/SB/SH/SW.
  - FSM state encodings ST_IDLE/ST_WAIT.
- Sub-module mem_lane_align (combinational): funct3 + addr[1:0] + rs2/rdata -> be, wdata, load data.

Test Plan:
1. ALU op, ex_alu_result=0x1234 rd=5 regWrite=1 -> next cycle wb_mem_data=0x1234, wb_reg_write=1, wb_mem_to_reg=0, mem_stall never high.
2. SB addr=0x1003 rs2=0xAABBCCDD, ready at first req cycle -> dmem_addr=0x1000, be=4'b1000, wdata=0xDDDDDDDD, stall 2 cycles, wb_reg_write=0.
3. LH addr=0x2002, rdata=0x8765_4321, ready after 3 wait cycles -> wb_mem_data=0x00008765, wb_funct3=LH, wb_mem_to_reg=1, dmem_req high exactly 4 cycles.
4. LW with dmem_ready never asserted, MAX_WAIT=4 -> req drops after 4 WAIT cycles, mem_err 1-cycle pulse, wb_reg_write=0, FSM in IDLE.
5. Assert rstn=0 mid-WAIT -> dmem_req and all wb_* go 0 asynchronously; the next ALU op completes normally after release.
6. With MEM_MISALIGN_TRAP_EN defined, LW addr=0x3001 -> no dmem_req, mem_misalign pulse, mem_bad_addr=0x3001, wb_reg_write=0.
